// File: rtl/sigma_pkg.sv
// Shared Sigma definitions: opcode constants, operand-size classes and the
// state encoding of the effective-address engine.
package sigma_pkg;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE} size_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DECODE, ST_IMM, ST_IND, ST_INDEX, ST_OPF, ST_FAULT, ST_DONE
    } state_e;

    localparam logic [6:0] OP_LCFI = 7'h02;
    localparam logic [6:0] OP_AD   = 7'h10;
    localparam logic [6:0] OP_CD   = 7'h11;
    localparam logic [6:0] OP_LD   = 7'h12;
    localparam logic [6:0] OP_STD  = 7'h15;
    localparam logic [6:0] OP_AI   = 7'h20;
    localparam logic [6:0] OP_CI   = 7'h21;
    localparam logic [6:0] OP_LI   = 7'h22;
    localparam logic [6:0] OP_MI   = 7'h23;
    localparam logic [6:0] OP_AW   = 7'h30;
    localparam logic [6:0] OP_CW   = 7'h31;
    localparam logic [6:0] OP_LW   = 7'h32;
    localparam logic [6:0] OP_STW  = 7'h35;
    localparam logic [6:0] OP_AH   = 7'h50;
    localparam logic [6:0] OP_CH   = 7'h51;
    localparam logic [6:0] OP_LH   = 7'h52;
    localparam logic [6:0] OP_STH  = 7'h55;
    localparam logic [6:0] OP_CB   = 7'h71;
    localparam logic [6:0] OP_LB   = 7'h72;
    localparam logic [6:0] OP_STB  = 7'h75;

    // Anything not listed as byte/half/double addresses a full word.
    function automatic size_e op_size(input logic [6:0] op);
        case (op)
            OP_CB, OP_LB, OP_STB:          return SZ_BYTE;
            OP_AH, OP_CH, OP_LH, OP_STH:   return SZ_HALF;
            OP_AD, OP_CD, OP_LD, OP_STD:   return SZ_DOUBLE;
            default:                       return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_is_immediate(input logic [6:0] op);
        return op inside {OP_LCFI, OP_AI, OP_CI, OP_LI, OP_MI};
    endfunction

endpackage

// File: rtl/sigma_ea_scale.sv
// Post-index adder: word reference promoted to a byte address plus the index
// register shifted by operand size; the sum wraps at ADDR_W+2 bits.
module sigma_ea_scale
    import sigma_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic [ADDR_W-1:0] i_ref,
    input  logic [31:0]       i_x,
    input  logic [1:0]        i_size,
    output logic [ADDR_W+1:0] o_ea
);

    logic [31:0] w_base;
    logic [31:0] w_off;

    always_comb begin
        w_base = 32'({i_ref, 2'b00});
        w_off  = i_x;
        case (size_e'(i_size))
            SZ_HALF:   w_off = i_x << 1;
            SZ_WORD:   w_off = i_x << 2;
            // doublewords are doubleword-aligned: the low ref bit is dropped
            SZ_DOUBLE: begin
                w_base = 32'({i_ref[ADDR_W-1:1], 3'b000});
                w_off  = i_x << 3;
            end
            default: ;
        endcase
    end

    assign o_ea = (ADDR_W+2)'(w_base + w_off);

endmodule

// File: rtl/sigma_ea_unit.sv
// Sigma effective-address / operand-fetch engine: immediate decode, bounded
// indirection, size-scaled post-indexing and an optional operand read.
module sigma_ea_unit
    import sigma_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int MAX_INDIRECT = 1,
    parameter int FETCH_ENABLE = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       instr,
    input  logic              fetch_op,
    output logic              busy,
    output logic [2:0]        x_sel,
    input  logic [31:0]       x_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic [ADDR_W+1:0] ea,
    output logic [31:0]       operand,
    output logic              immediate,
    output logic              fault
);

    state_e            r_state, w_next;
    logic [7:0]        r_hdr;       // {I, opcode}
    logic [19:0]       r_low;       // {X, ref}, also the immediate field
    logic [ADDR_W-1:0] r_ref;
    logic              r_fop;
    logic [7:0]        r_lvl;
    logic [ADDR_W+1:0] r_ea;
    logic [31:0]       r_operand;
    logic              r_immediate;
    logic              r_fault;

    logic [6:0]        w_op;
    logic [2:0]        w_xs;
    logic [31:0]       w_x;
    logic [ADDR_W+1:0] w_ea;
    logic              w_chain;
    logic              w_more;
    logic              w_fetch;

    assign w_op    = r_hdr[6:0];
    assign w_xs    = r_low[19:17];
    assign w_x     = (w_xs == 3'd0) ? 32'd0 : x_data;
    // with a single allowed level the chain bit is ignored entirely
    assign w_chain = (MAX_INDIRECT > 1) && mem_rdata[31];
    assign w_more  = r_lvl < 8'(MAX_INDIRECT);
    assign w_fetch = r_fop && (FETCH_ENABLE != 0);

    sigma_ea_scale #(.ADDR_W(ADDR_W)) u_scale (
        .i_ref  (r_ref),
        .i_x    (w_x),
        .i_size (op_size(w_op)),
        .o_ea   (w_ea)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_DECODE;
            ST_DECODE: begin
                if (op_is_immediate(w_op)) w_next = ST_IMM;
                else if (r_hdr[7])         w_next = ST_IND;
                else                       w_next = ST_INDEX;
            end
            ST_IMM:    w_next = ST_DONE;
            ST_IND: begin
                if (mem_ready) begin
                    if (w_chain) w_next = w_more ? ST_IND : ST_FAULT;
                    else         w_next = ST_INDEX;
                end
            end
            ST_INDEX:  w_next = w_fetch ? ST_OPF : ST_DONE;
            ST_OPF:    if (mem_ready) w_next = ST_DONE;
            ST_FAULT:  w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done     = (r_state == ST_DONE);
        mem_req  = (r_state == ST_IND) || (r_state == ST_OPF);
        mem_addr = '0;
        x_sel    = 3'd0;
        if (r_state == ST_IND)   mem_addr = r_ref;
        if (r_state == ST_OPF)   mem_addr = r_ea[ADDR_W+1:2];
        if (r_state == ST_INDEX) x_sel = w_xs;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hdr       <= '0;
            r_low       <= '0;
            r_ref       <= '0;
            r_fop       <= 1'b0;
            r_lvl       <= '0;
            r_ea        <= '0;
            r_operand   <= '0;
            r_immediate <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_hdr       <= instr[31:24];
                    r_low       <= instr[19:0];
                    r_ref       <= instr[ADDR_W-1:0];
                    r_fop       <= fetch_op;
                    r_lvl       <= 8'd1;
                    r_ea        <= '0;
                    r_operand   <= '0;
                    r_immediate <= 1'b0;
                    r_fault     <= 1'b0;
                end
                ST_IMM: begin
                    r_operand   <= {{12{r_low[19]}}, r_low};
                    r_immediate <= 1'b1;
                end
                ST_IND: if (mem_ready) begin
                    r_ref <= mem_rdata[ADDR_W-1:0];
                    if (w_chain && w_more) r_lvl <= r_lvl + 8'd1;
                end
                ST_INDEX: r_ea <= w_ea;
                ST_OPF:   if (mem_ready) r_operand <= mem_rdata;
                ST_FAULT: begin
                    r_ea      <= '0;
                    r_operand <= '0;
                    r_fault   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ea        = r_ea;
    assign operand   = r_operand;
    assign immediate = r_immediate;
    assign fault     = r_fault;

endmodule

// File: tb/tb_sigma_ea_unit.sv
// Scoreboard bench for sigma_ea_unit: two instances (MAX_INDIRECT 1 and 2) share
// stimulus; a reference model predicts each completion, a monitor checks it.
module tb_sigma_ea_unit;

    localparam int AW = 17;

    typedef struct {
        logic [AW+1:0] ea;
        logic [31:0]   op;
        logic          imm;
        logic          flt;
        int            lat;
        int            nreq;
        int            t0;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   instr = '0;
    logic          fetch_op = 1'b0;

    logic          busy[2];
    logic [2:0]    x_sel[2];
    logic [31:0]   x_data[2];
    logic          mem_req[2];
    logic [AW-1:0] mem_addr[2];
    logic          mem_ready[2];
    logic [31:0]   mem_rdata[2];
    logic          done[2];
    logic [AW+1:0] ea[2];
    logic [31:0]   operand[2];
    logic          immediate[2];
    logic          fault[2];

    logic [31:0]   rf[8];
    logic [31:0]   mem[int];
    exp_t          q0[$];
    exp_t          q1[$];
    int            nchk = 0, nerr = 0, cyc = 0, wait_n = 0;
    int            wcnt[2], nreq_seen[2];
    logic [AW-1:0] held[2];
    bit            expect_none = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign x_data[0] = rf[x_sel[0]];
    assign x_data[1] = rf[x_sel[1]];

    sigma_ea_unit #(.ADDR_W(AW), .MAX_INDIRECT(1), .FETCH_ENABLE(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .instr(instr), .fetch_op(fetch_op),
        .busy(busy[0]), .x_sel(x_sel[0]), .x_data(x_data[0]), .mem_req(mem_req[0]),
        .mem_addr(mem_addr[0]), .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]),
        .done(done[0]), .ea(ea[0]), .operand(operand[0]), .immediate(immediate[0]),
        .fault(fault[0]));

    sigma_ea_unit #(.ADDR_W(AW), .MAX_INDIRECT(2), .FETCH_ENABLE(1)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .start(start), .instr(instr), .fetch_op(fetch_op),
        .busy(busy[1]), .x_sel(x_sel[1]), .x_data(x_data[1]), .mem_req(mem_req[1]),
        .mem_addr(mem_addr[1]), .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]),
        .done(done[1]), .ea(ea[1]), .operand(operand[1]), .immediate(immediate[1]),
        .fault(fault[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Unwritten memory reads back a pattern derived from its address, bit 0 clear.
    function automatic logic [31:0] rd(input int a);
        return mem.exists(a) ? mem[a] : (32'h00A5_0000 ^ 32'(a));
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input bit fop, input int maxi);
        exp_t    e;
        int      opc, r, lvl, xs, sh, v;
        longint  base, s;
        logic [31:0] w, x;
        e = '{ea: '0, op: '0, imm: 1'b0, flt: 1'b0, lat: 0, nreq: 0, t0: 0};
        opc = int'(ins[30:24]);
        if (opc inside {'h02, 'h20, 'h21, 'h22, 'h23}) begin
            v = int'(ins[19:0]);
            if (v >= 524288) v -= 1048576;
            e.op  = 32'(v);
            e.imm = 1'b1;
        end else begin
            r = int'(ins[16:0]);
            if (ins[31]) begin
                lvl = 1;
                forever begin
                    w = rd(r);
                    e.nreq++;
                    r = int'(w[16:0]);
                    if (maxi > 1 && w[31]) begin
                        if (lvl < maxi) lvl++;
                        else begin e.flt = 1'b1; break; end
                    end else break;
                end
            end
            if (!e.flt) begin
                xs = int'(ins[19:17]);
                x  = (xs == 0) ? 32'd0 : rf[xs];
                base = longint'(r) * 4;
                if (opc inside {'h71, 'h72, 'h75})            sh = 0;
                else if (opc inside {'h50, 'h51, 'h52, 'h55}) sh = 1;
                else if (opc inside {'h10, 'h11, 'h12, 'h15}) begin
                    sh = 3;
                    base = longint'(r - (r % 2)) * 4;
                end else sh = 2;
                s = (base + longint'(x) * (longint'(1) << sh)) % (longint'(1) << (AW + 2));
                e.ea = (AW+2)'(s);
                if (fop) begin
                    e.op = rd(int'(s / 4));
                    e.nreq++;
                end
            end
        end
        e.lat = 3 + e.nreq * (1 + wait_n);
        return e;
    endfunction

    // Monitor/scoreboard plus per-instance wait-state memory responder.
    always @(negedge clock) begin
        exp_t e;
        int   sz;
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                if (done[d]) begin
                    sz = (d == 0) ? q0.size() : q1.size();
                    if (expect_none) begin
                        nchk++; nerr++;
                        $display("FAIL d%0d_done_after_reset: done pulsed, required none", d);
                    end else if (sz == 0) begin
                        nchk++; nerr++;
                        $display("FAIL d%0d_unexpected_done: done with empty scoreboard", d);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("d%0d_ea", d), 64'(ea[d]), 64'(e.ea));
                        chk($sformatf("d%0d_operand", d), 64'(operand[d]), 64'(e.op));
                        chk($sformatf("d%0d_immediate", d), 64'(immediate[d]), 64'(e.imm));
                        chk($sformatf("d%0d_fault", d), 64'(fault[d]), 64'(e.flt));
                        chk($sformatf("d%0d_latency", d), 64'(cyc - e.t0), 64'(e.lat));
                        chk($sformatf("d%0d_mem_reads", d), 64'(nreq_seen[d]), 64'(e.nreq));
                        chk($sformatf("d%0d_busy_at_done", d), 64'(busy[d]), 64'd0);
                    end
                    nreq_seen[d] = 0;
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (!reset_n || !mem_req[d]) begin
                mem_ready[d] = 1'b0;
                wcnt[d]      = 0;
            end else begin
                if (wcnt[d] > 0) chk($sformatf("d%0d_addr_stable", d), 64'(mem_addr[d]), 64'(held[d]));
                else held[d] = mem_addr[d];
                mem_rdata[d] = rd(int'(mem_addr[d]));
                if (wcnt[d] >= wait_n) begin
                    mem_ready[d] = 1'b1;
                    wcnt[d]      = 0;
                    nreq_seen[d]++;
                end else begin
                    mem_ready[d] = 1'b0;
                    wcnt[d]++;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input bit fop);
        exp_t e;
        @(negedge clock);
        e = model(ins, fop, 1); e.t0 = cyc; q0.push_back(e);
        e = model(ins, fop, 2); e.t0 = cyc; q1.push_back(e);
        instr = ins; fetch_op = fop; start = 1'b1;
        @(negedge clock);
        start = 1'b0; instr = $urandom; fetch_op = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (q0.size() == 0 && q1.size() == 0 && !busy[0] && !busy[1]) return;
        end
        nchk++; nerr++;
        $display("FAIL wait_idle_timeout: pending %0d/%0d, required 0/0", q0.size(), q1.size());
        q0.delete(); q1.delete();
    endtask

    function automatic logic [31:0] mk(input bit i, input logic [6:0] op, input int x, input int r);
        return {i, op, 4'h1, 3'(x), 17'(r)};
    endfunction

    initial begin
        logic [6:0] ops[18];
        bit ok;
        ops = '{7'h02, 7'h20, 7'h21, 7'h22, 7'h23, 7'h71, 7'h72, 7'h75, 7'h50,
                7'h51, 7'h52, 7'h55, 7'h10, 7'h12, 7'h15, 7'h30, 7'h32, 7'h35};
        for (int i = 0; i < 8; i++) rf[i] = 32'h7000_0000 + 32'(i);
        for (int d = 0; d < 2; d++) begin
            mem_ready[d] = 1'b0; mem_rdata[d] = '0; wcnt[d] = 0; nreq_seen[d] = 0;
        end
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_flags", d),
                64'({busy[d], done[d], mem_req[d], immediate[d], fault[d], x_sel[d]}), 64'd0);
            chk($sformatf("d%0d_rst_data", d), 64'({ea[d], operand[d], mem_addr[d]}), 64'd0);
        end
        reset_n = 1'b1;

        // LI R1,-5 : sign-extended immediate, no memory traffic
        issue(32'h221F_FFFB, 1'b1); wait_idle();
        // LW ref=0x100, X=2, rr2=3, fetch
        rf[2] = 32'd3; mem[32'h103] = 32'hDEAD_BEEF;
        issue(mk(0, 7'h32, 2, 'h100), 1'b1); wait_idle();
        // LB ref=0x100, X=1, rr1=5, three wait states
        rf[1] = 32'd5; wait_n = 3;
        issue(mk(0, 7'h72, 1, 'h100), 1'b1); wait_idle();
        wait_n = 0;
        // indirect chain: ignored bit0 for one level, fault for two
        mem[32'h20] = 32'h8000_0040; mem[32'h40] = 32'h8000_0050;
        issue(mk(1, 7'h32, 0, 'h20), 1'b0); wait_idle();
        // wrap at 2^19, with a start pulsed while busy
        rf[1] = 32'd1;
        issue(mk(0, 7'h32, 1, 'h1FFFF), 1'b0);
        start = 1'b1; instr = 32'h2200_0001;
        @(negedge clock); start = 1'b0;
        wait_idle();
        // start in the DONE cycle is ignored
        issue(mk(0, 7'h32, 2, 'h10), 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (done[0]) break;
        end
        start = 1'b1; instr = 32'h2200_0002;
        @(negedge clock); start = 1'b0;
        wait_idle();
        // reset while an indirect read is waiting
        wait_n = 5;
        issue(mk(1, 7'h32, 0, 'h20), 1'b1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_req[0] && mem_req[1]) begin ok = 1; break; end
        end
        chk("rst_req_seen", 64'(ok), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_req", 64'({mem_req[0], mem_req[1]}), 64'd0);
        q0.delete(); q1.delete(); expect_none = 1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        chk("rst_busy_after", 64'({busy[0], busy[1]}), 64'd0);
        expect_none = 0; nreq_seen[0] = 0; nreq_seen[1] = 0; wait_n = 0;

        // randomized traffic
        for (int a = 0; a < 64; a++)
            mem[a] = {1'($urandom), 14'($urandom), 17'($urandom_range(0, 63))};
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 8; i++) rf[i] = $urandom;
            wait_n = $urandom_range(0, 2);
            issue({($urandom_range(0, 2) == 0), ops[$urandom_range(0, 17)], 4'($urandom),
                   3'($urandom), ($urandom_range(0, 3) == 0) ? 17'h1FFFF - 17'($urandom_range(0, 3))
                                                             : 17'($urandom_range(0, 63))},
                  1'($urandom));
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
